// File: rtl/mult_div_unit.sv
// -----------------------------------------------------------------------------
// mult_div_unit
//
// Execute-stage multiply/divide companion to the ALU of a 5-stage MIPS core.
// It runs mult/multu/div/divu into a pending {hi,lo} pair. It then holds
// o_busy for a fixed number of cycles. After that it commits the pending pair
// to the architectural HI/LO registers. mthi/mtlo write HI/LO directly in a
// single cycle.
//
// Optional feature (macro MDU_MADD_EN):
//   When the macro is defined:
//     i_op 110 is madd, a signed multiply-accumulate into {HI,LO}.
//     i_op 111 is maddu, the unsigned form of madd.
//   When the macro is undefined, both encodings are ignored.
//
// Parameters:
//   MULT_CYCLES : busy cycles after a mult/multu/madd/maddu start (>=1)
//   DIV_CYCLES  : busy cycles after a div/divu start (>=1)
//
// Ports:
//   clk      : clock, all state updates on the rising edge
//   reset    : synchronous active-high reset, clears all state
//   i_start  : one-cycle pulse, i_op/i_A/i_B are valid this cycle
//   i_op     : 000 mult, 001 multu, 010 div, 011 divu, 100 mthi, 101 mtlo,
//              110 madd, 111 maddu (110 and 111 only with MDU_MADD_EN)
//   i_A      : forwarded rs operand
//   i_B      : forwarded rt operand
//   o_busy   : high while a multi-cycle operation is in flight
//   o_HI     : committed HI register
//   o_LO     : committed LO register
// -----------------------------------------------------------------------------
module mult_div_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_start,
  input  logic [2:0]  i_op,
  input  logic [31:0] i_A,
  input  logic [31:0] i_B,
  output logic        o_busy,
  output logic [31:0] o_HI,
  output logic [31:0] o_LO
);

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;
`ifdef MDU_MADD_EN
  localparam logic [2:0] OP_MADD  = 3'b110;
  localparam logic [2:0] OP_MADDU = 3'b111;
`endif

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW         = $clog2(MAX_CYCLES + 1);
  localparam logic [CW-1:0] MULT_LOAD = CW'(MULT_CYCLES);
  localparam logic [CW-1:0] DIV_LOAD  = CW'(DIV_CYCLES);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);

  typedef enum logic {
    ST_IDLE,
    ST_BUSY
  } state_t;

  state_t        state_q;
  logic [CW-1:0] count_q;
  logic [31:0]   pend_hi_q;
  logic [31:0]   pend_lo_q;
  logic          pend_valid_q;
  logic [31:0]   hi_q;
  logic [31:0]   lo_q;
  logic          busy_q;

  // ---------------------------------------------------------------------------
  // Start-cycle arithmetic (operands sampled only at the start edge)
  // ---------------------------------------------------------------------------
  // The even opcodes mult/div/madd are signed. The odd opcodes are unsigned.
  logic        is_signed_d;
  logic [63:0] ext_a_d;
  logic [63:0] ext_b_d;
  logic [63:0] prod_d;
  logic        a_neg_d;
  logic        b_neg_d;
  logic [31:0] abs_a_d;
  logic [31:0] abs_b_d;
  logic [31:0] divisor_d;
  logic [31:0] uquot_d;
  logic [31:0] urem_d;
  logic [31:0] quot_d;
  logic [31:0] rem_d;
`ifdef MDU_MADD_EN
  logic [63:0] madd_d;
`endif

  always_comb begin
    is_signed_d = ~i_op[0];

    // A 64x64 product truncated to 64 bits is exact for sign- or zero-extended
    // 32-bit operands, so one unsigned multiplier covers both signednesses.
    ext_a_d = is_signed_d ? {{32{i_A[31]}}, i_A} : {32'b0, i_A};
    ext_b_d = is_signed_d ? {{32{i_B[31]}}, i_B} : {32'b0, i_B};
    prod_d  = ext_a_d * ext_b_d;

    // Signed division is done on magnitudes. The quotient is then negated if
    // the operand signs differ, which truncates toward zero. The remainder
    // takes the dividend's sign. For 0x80000000 / -1 the magnitude quotient
    // is 0x80000000 with positive sign, which gives the required wrap result.
    a_neg_d   = is_signed_d & i_A[31];
    b_neg_d   = is_signed_d & i_B[31];
    abs_a_d   = a_neg_d ? (32'd0 - i_A) : i_A;
    abs_b_d   = b_neg_d ? (32'd0 - i_B) : i_B;
    // Keep the divider well defined on /0. Its result is discarded anyway.
    divisor_d = (i_B == 32'd0) ? 32'd1 : abs_b_d;
    uquot_d   = abs_a_d / divisor_d;
    urem_d    = abs_a_d % divisor_d;
    quot_d    = (a_neg_d ^ b_neg_d) ? (32'd0 - uquot_d) : uquot_d;
    rem_d     = a_neg_d ? (32'd0 - urem_d) : urem_d;

`ifdef MDU_MADD_EN
    madd_d = {hi_q, lo_q} + prod_d;
`endif
  end

  // ---------------------------------------------------------------------------
  // Control FSM and architectural state
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      count_q      <= '0;
      pend_hi_q    <= '0;
      pend_lo_q    <= '0;
      pend_valid_q <= 1'b0;
      hi_q         <= '0;
      lo_q         <= '0;
      busy_q       <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (i_start) begin
            case (i_op)
              OP_MULT, OP_MULTU: begin
                pend_hi_q    <= prod_d[63:32];
                pend_lo_q    <= prod_d[31:0];
                pend_valid_q <= 1'b1;
                count_q      <= MULT_LOAD;
                busy_q       <= 1'b1;
                state_q      <= ST_BUSY;
              end
              OP_DIV, OP_DIVU: begin
                pend_hi_q    <= rem_d;
                pend_lo_q    <= quot_d;
                // Divide by zero still occupies the unit but never commits.
                pend_valid_q <= (i_B != 32'd0);
                count_q      <= DIV_LOAD;
                busy_q       <= 1'b1;
                state_q      <= ST_BUSY;
              end
              OP_MTHI: hi_q <= i_A;
              OP_MTLO: lo_q <= i_A;
`ifdef MDU_MADD_EN
              OP_MADD, OP_MADDU: begin
                pend_hi_q    <= madd_d[63:32];
                pend_lo_q    <= madd_d[31:0];
                pend_valid_q <= 1'b1;
                count_q      <= MULT_LOAD;
                busy_q       <= 1'b1;
                state_q      <= ST_BUSY;
              end
`endif
              default: ;
            endcase
          end
        end
        ST_BUSY: begin
          // i_start is deliberately ignored here. The hazard unit prevents it.
          if (count_q == CNT_ONE) begin
            if (pend_valid_q) begin
              hi_q <= pend_hi_q;
              lo_q <= pend_lo_q;
            end
            pend_valid_q <= 1'b0;
            count_q      <= '0;
            busy_q       <= 1'b0;
            state_q      <= ST_IDLE;
          end else begin
            count_q <= count_q - CNT_ONE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign o_busy = busy_q;
  assign o_HI   = hi_q;
  assign o_LO   = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// -----------------------------------------------------------------------------
// tb_mult_div_unit
//
// Self-checking bench for mult_div_unit. The bench applies a table of directed
// operations with hand-computed HI/LO values and busy lengths. It then runs
// hand-written sequences for the following cases:
//   - reset
//   - back-to-back mthi/mtlo
//   - a start that arrives while the unit is busy
//   - a reset in the middle of an operation
// Define MDU_MADD_EN for both files to exercise madd/maddu.
// -----------------------------------------------------------------------------
module tb_mult_div_unit;

  localparam int MC = 5;
  localparam int DC = 10;

  logic        clk;
  logic        reset;
  logic        i_start;
  logic [2:0]  i_op;
  logic [31:0] i_A;
  logic [31:0] i_B;
  logic        o_busy;
  logic [31:0] o_HI;
  logic [31:0] o_LO;

  int total;
  int bad;

  // Architectural HI/LO the bench expects to be committed right now.
  logic [31:0] cur_hi;
  logic [31:0] cur_lo;

  mult_div_unit #(
    .MULT_CYCLES(MC),
    .DIV_CYCLES (DC)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .i_start(i_start),
    .i_op   (i_op),
    .i_A    (i_A),
    .i_B    (i_B),
    .o_busy (o_busy),
    .o_HI   (o_HI),
    .o_LO   (o_LO)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    int          cycles;
  } vec_t;

  localparam int NV = 15;
  vec_t vecs [NV];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Apply one operation. Count busy cycles at falling edges, with a bound.
  // Check that HI/LO hold their committed values while busy, then check the
  // final values.
  task automatic apply(input vec_t v, input int idx);
    int n;
    @(negedge clk);
    i_start = 1'b1;
    i_op    = v.op;
    i_A     = v.a;
    i_B     = v.b;
    @(posedge clk);
    #1 i_start = 1'b0;
    n = 0;
    @(negedge clk);
    while (o_busy && n < 40) begin
      if (n == 0) begin
        check($sformatf("v%0d busy_hi", idx), o_HI, cur_hi);
        check($sformatf("v%0d busy_lo", idx), o_LO, cur_lo);
      end
      n++;
      @(negedge clk);
    end
    check($sformatf("v%0d busy_cycles", idx), 32'(n), 32'(v.cycles));
    check($sformatf("v%0d hi", idx), o_HI, v.hi);
    check($sformatf("v%0d lo", idx), o_LO, v.lo);
    $display("vec %0d op=%0d A=%h B=%h busy=%0d HI=%h LO=%h", idx, v.op, v.a, v.b, n, o_HI, o_LO);
    cur_hi = v.hi;
    cur_lo = v.lo;
  endtask

  initial begin
    int n;
    vec_t mv;
    total   = 0;
    bad     = 0;
    cur_hi  = '0;
    cur_lo  = '0;

    vecs[0]  = '{3'b000, 32'hFFFFFFFE, 32'd3,        32'hFFFFFFFF, 32'hFFFFFFFA, MC};
    vecs[1]  = '{3'b001, 32'hFFFFFFFE, 32'd3,        32'h00000002, 32'hFFFFFFFA, MC};
    vecs[2]  = '{3'b010, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, DC};
    vecs[3]  = '{3'b011, 32'd7,        32'd0,        32'hFFFFFFFF, 32'hFFFFFFFD, DC};
    vecs[4]  = '{3'b010, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, DC};
    vecs[5]  = '{3'b011, 32'd100,      32'd7,        32'h00000002, 32'h0000000E, DC};
    vecs[6]  = '{3'b010, 32'd100,      32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFF2, DC};
    vecs[7]  = '{3'b010, 32'hFFFFFFF9, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'h00000003, DC};
    vecs[8]  = '{3'b000, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, MC};
    vecs[9]  = '{3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, MC};
    vecs[10] = '{3'b100, 32'h12345678, 32'd0,        32'h12345678, 32'h00000001, 0};
    vecs[11] = '{3'b101, 32'h9ABCDEF0, 32'd0,        32'h12345678, 32'h9ABCDEF0, 0};
`ifdef MDU_MADD_EN
    vecs[12] = '{3'b110, 32'd2,        32'd3,        32'h12345678, 32'h9ABCDEF6, MC};
    vecs[13] = '{3'b111, 32'hFFFFFFFF, 32'd2,        32'h1234567A, 32'h9ABCDEF4, MC};
    vecs[14] = '{3'b011, 32'd0,        32'd5,        32'h00000000, 32'h00000000, DC};
`else
    vecs[12] = '{3'b110, 32'd2,        32'd3,        32'h12345678, 32'h9ABCDEF0, 0};
    vecs[13] = '{3'b111, 32'hFFFFFFFF, 32'd2,        32'h12345678, 32'h9ABCDEF0, 0};
    vecs[14] = '{3'b011, 32'd0,        32'd5,        32'h00000000, 32'h00000000, DC};
`endif

    // Reset for two cycles while a mult start is presented. The start must be
    // ignored.
    reset   = 1'b1;
    i_start = 1'b1;
    i_op    = 3'b000;
    i_A     = 32'd7;
    i_B     = 32'd9;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    i_start = 1'b0;
    @(negedge clk);
    check("rst busy", 32'(o_busy), 32'd0);
    check("rst hi", o_HI, 32'd0);
    check("rst lo", o_LO, 32'd0);
    @(negedge clk);
    check("rst busy2", 32'(o_busy), 32'd0);
    $display("reset: busy=%0d HI=%h LO=%h", o_busy, o_HI, o_LO);

    // Run the directed table.
    for (int i = 0; i < NV; i++) apply(vecs[i], i);

    // Start a mult 3*4. A div start arrives at busy cycle 2 and must be
    // ignored.
    @(negedge clk);
    i_start = 1'b1; i_op = 3'b000; i_A = 32'd3; i_B = 32'd4;
    @(posedge clk);
    #1 i_start = 1'b0;
    n = 0;
    @(negedge clk);
    while (o_busy && n < 40) begin
      n++;
      if (n == 2) begin
        i_start = 1'b1; i_op = 3'b010; i_A = 32'd100; i_B = 32'd7;
        @(posedge clk);
        #1 i_start = 1'b0;
      end
      @(negedge clk);
    end
    check("ovl busy_cycles", 32'(n), 32'(MC));
    check("ovl hi", o_HI, 32'd0);
    check("ovl lo", o_LO, 32'd12);
    repeat (3) @(negedge clk);
    check("ovl busy_after", 32'(o_busy), 32'd0);
    check("ovl lo_after", o_LO, 32'd12);
    $display("overlap: busy=%0d HI=%h LO=%h", n, o_HI, o_LO);

    // Issue mthi then mtlo on consecutive cycles.
    @(negedge clk);
    i_start = 1'b1; i_op = 3'b100; i_A = 32'hAAAA0001; i_B = 32'd0;
    @(posedge clk);
    @(negedge clk);
    check("mthi hi", o_HI, 32'hAAAA0001);
    check("mthi lo", o_LO, 32'd12);
    check("mthi busy", 32'(o_busy), 32'd0);
    i_op = 3'b101; i_A = 32'h5555000F;
    @(posedge clk);
    #1 i_start = 1'b0;
    @(negedge clk);
    check("mtlo hi", o_HI, 32'hAAAA0001);
    check("mtlo lo", o_LO, 32'h5555000F);
    check("mtlo busy", 32'(o_busy), 32'd0);
    $display("mthi/mtlo: HI=%h LO=%h busy=%0d", o_HI, o_LO, o_busy);

    // Assert reset in the middle of a div. The aborted result must never
    // commit.
    @(negedge clk);
    i_start = 1'b1; i_op = 3'b010; i_A = 32'd100; i_B = 32'd7;
    @(posedge clk);
    #1 i_start = 1'b0;
    n = 0;
    @(negedge clk);
    while (o_busy && n < 4) begin
      n++;
      if (n == 4) begin
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
      end
      @(negedge clk);
    end
    check("abort busy", 32'(o_busy), 32'd0);
    check("abort hi", o_HI, 32'd0);
    check("abort lo", o_LO, 32'd0);
    repeat (15) @(negedge clk);
    check("abort busy_late", 32'(o_busy), 32'd0);
    check("abort hi_late", o_HI, 32'd0);
    check("abort lo_late", o_LO, 32'd0);
    $display("abort: busy=%0d HI=%h LO=%h", o_busy, o_HI, o_LO);
    cur_hi = '0;
    cur_lo = '0;

`ifdef MDU_MADD_EN
    // Accumulate onto HI:LO = 0:5 with madd 2*3, which gives LO = 11.
    mv = '{3'b101, 32'd5, 32'd0, 32'd0, 32'd5, 0};
    apply(mv, 100);
    mv = '{3'b110, 32'd2, 32'd3, 32'd0, 32'd11, MC};
    apply(mv, 101);
`else
    // Check that 110 is ignored even right after a reset.
    mv = '{3'b110, 32'd2, 32'd3, 32'd0, 32'd0, 0};
    apply(mv, 100);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
